// File: rtl/pixel_fetch.sv
// Framebuffer pixel fetcher: issues pipelined Avalon-MM word reads for one frame
// and forwards returned pixels into the scanout FIFO, with flow control and restart flush.
module pixel_fetch #(
    parameter logic [23:0] FB_BASE     = 24'h000000,
    parameter int unsigned PIXELS      = 384000,
    parameter int unsigned FIFO_DEPTH  = 512,
    parameter int unsigned MAX_PENDING = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_restart,
    output logic        mem_read,
    output logic [23:0] mem_address,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    input  logic        mem_readdatavalid,
    output logic        fifo_wrreq,
    output logic [23:0] fifo_data,
    input  logic [9:0]  fifo_wrusedw,
    input  logic        fifo_wrfull,
    output logic        fifo_sclr,
    output logic        overflow
);

    localparam int unsigned IDX_W  = 19;
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned PIX_W  = 24;
    localparam int unsigned CMP_W  = 11;
    localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

    localparam logic [1:0] S_FLUSH = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_FETCH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PIXELS - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
    localparam logic [CMP_W-1:0]  DEPTH_C  = CMP_W'(FIFO_DEPTH);

    logic [1:0]        state_q,    state_d;
    logic [PEND_W-1:0] pending_q,  pending_d;
    logic [IDX_W-1:0]  idx_q,      idx_d;
    logic              mem_read_q, mem_read_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic              wrreq_q,    wrreq_d;
    logic [PIX_W-1:0]  data_q,     data_d;
    logic              sclr_q,     sclr_d;
    logic              ovf_q,      ovf_d;

    logic accept_c;
    logic ret_c;
    logic can_issue_c;
    logic unused_rd_hi;

    assign unused_rd_hi = ^mem_readdata[31:24];

    // Next-state, request generation and return datapath
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        idx_d      = idx_q;
        mem_read_d = mem_read_q;
        wrreq_d    = 1'b0;
        data_d     = data_q;
        ovf_d      = ovf_q;

        accept_c = mem_read_q && !mem_waitrequest;
        ret_c    = mem_readdatavalid && (pending_q != '0);

        if (accept_c && !ret_c) begin
            pending_d = pending_q + PEND_W'(1);
        end else if (!accept_c && ret_c) begin
            pending_d = pending_q - PEND_W'(1);
        end

        case (state_q)
            S_FLUSH: begin
                idx_d = '0;
                if (pending_d == '0) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                idx_d = '0;
                if (!frame_restart) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (accept_c) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end
                end
                if (frame_restart) begin
                    state_d = S_FLUSH;
                    idx_d   = '0;
                end
            end
            default: begin
                if (frame_restart) begin
                    state_d = S_FLUSH;
                    idx_d   = '0;
                end
            end
        endcase

        // Budget includes this cycle's acceptance/return so pending never exceeds the limit
        can_issue_c = (pending_d < PEND_MAX) &&
                      ((CMP_W'(fifo_wrusedw) + CMP_W'(pending_d)) < DEPTH_C);

        if (state_d != S_FETCH) begin
            mem_read_d = 1'b0;
        end else if (!mem_read_q || accept_c) begin
            mem_read_d = can_issue_c;
        end

        addr_d = FB_BASE + ADDR_W'(idx_d);

        if ((state_q == S_FETCH || state_q == S_DONE) && mem_readdatavalid) begin
            if (fifo_wrfull) begin
                ovf_d = 1'b1;
            end else begin
                wrreq_d = 1'b1;
                data_d  = mem_readdata[PIX_W-1:0];
            end
        end

        if (state_d == S_FLUSH && state_q != S_FLUSH) begin
            ovf_d = 1'b0;
        end

        sclr_d = (state_d == S_FLUSH) || (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_FLUSH;
            pending_q  <= '0;
            idx_q      <= '0;
            mem_read_q <= 1'b0;
            addr_q     <= FB_BASE;
            wrreq_q    <= 1'b0;
            data_q     <= '0;
            sclr_q     <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            idx_q      <= idx_d;
            mem_read_q <= mem_read_d;
            addr_q     <= addr_d;
            wrreq_q    <= wrreq_d;
            data_q     <= data_d;
            sclr_q     <= sclr_d;
            ovf_q      <= ovf_d;
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_address = addr_q;
    assign fifo_wrreq  = wrreq_q;
    assign fifo_data   = data_q;
    assign fifo_sclr   = sclr_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_pixel_fetch.sv
// Bench for pixel_fetch: randomized Avalon slave and FIFO stimulus against a
// transaction-level model of issued addresses, returned words and expected FIFO writes.
module tb_pixel_fetch;

    localparam logic [23:0] BASE  = 24'hFFFFF0;
    localparam int          PIX   = 300;
    localparam int          DEPTH = 512;
    localparam int          MAXP  = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_restart;
    logic        mem_read;
    logic [23:0] mem_address;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;
    logic        fifo_wrreq;
    logic [23:0] fifo_data;
    logic [9:0]  fifo_wrusedw;
    logic        fifo_wrfull;
    logic        fifo_sclr;
    logic        overflow;

    pixel_fetch #(
        .FB_BASE    (BASE),
        .PIXELS     (PIX),
        .FIFO_DEPTH (DEPTH),
        .MAX_PENDING(MAXP)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .frame_restart    (frame_restart),
        .mem_read         (mem_read),
        .mem_address      (mem_address),
        .mem_waitrequest  (mem_waitrequest),
        .mem_readdata     (mem_readdata),
        .mem_readdatavalid(mem_readdatavalid),
        .fifo_wrreq       (fifo_wrreq),
        .fifo_data        (fifo_data),
        .fifo_wrusedw     (fifo_wrusedw),
        .fifo_wrfull      (fifo_wrfull),
        .fifo_sclr        (fifo_sclr),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          ready;
        int          epoch;
    } rd_t;

    rd_t rq[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int epoch = 0;
    int issued = 0;
    int outstanding = 0;
    int dut_writes = 0;
    int hold_cnt = 0;
    int wait_pct = 0;
    int ret_pct = 100;
    int lat_min = 3;
    int lat_max = 3;
    bit ret_en = 1'b1;
    bit ret_old_only = 1'b0;
    bit force_wait = 1'b0;
    bit hold7 = 1'b1;
    bit full_once = 1'b0;
    bit fr_cmd = 1'b0;
    bit fr_prev = 1'b0;
    logic        exp_wr = 1'b0;
    logic [23:0] exp_data = '0;
    logic        exp_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check what the last edge produced, then drive the next edge's inputs
    task automatic step();
        logic        acc, vld, wt, full;
        logic [31:0] rdat;
        logic [23:0] ea;
        int          e;
        rd_t         r;
        @(negedge clk);
        cyc++;
        chk("fifo_wrreq", 32'(fifo_wrreq), 32'(exp_wr));
        if (fifo_wrreq) dut_writes++;
        if (exp_wr) chk("fifo_data", 32'(fifo_data), 32'(exp_data));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        if (fr_prev) begin
            chk("restart_mem_read", 32'(mem_read), 32'(0));
            chk("restart_sclr", 32'(fifo_sclr), 32'(1));
        end
        if (mem_read) chk("fetch_sclr", 32'(fifo_sclr), 32'(0));

        if (mem_read) begin
            ea = BASE + 24'(issued);
            chk("mem_address", 32'(mem_address), 32'(ea));
            if (force_wait) wt = 1'b1;
            else if (hold7 && issued == 7 && hold_cnt < 5) begin
                wt = 1'b1;
                hold_cnt++;
            end else wt = (int'($urandom_range(99)) < wait_pct);
        end else begin
            wt = 1'($urandom_range(1));
        end
        acc = mem_read && !wt;

        vld  = 1'b0;
        full = 1'b0;
        rdat = $urandom;
        e    = -1;
        if (ret_en && rq.size() > 0 && rq[0].ready <= cyc &&
            (!ret_old_only || rq[0].epoch != epoch) &&
            int'($urandom_range(99)) < ret_pct) begin
            vld  = 1'b1;
            rdat = rq[0].data;
            e    = rq[0].epoch;
            void'(rq.pop_front());
        end
        if (vld && e == epoch && full_once) begin
            full      = 1'b1;
            full_once = 1'b0;
        end
        exp_wr   = vld && e == epoch && !full;
        exp_data = rdat[23:0];
        if (vld && e == epoch && full) exp_ovf = 1'b1;

        if (acc) begin
            chk("pending_limit", 32'(outstanding < MAXP), 32'(1));
            chk("fifo_budget", 32'((int'(fifo_wrusedw) + outstanding) < DEPTH), 32'(1));
            r.data  = $urandom;
            r.ready = cyc + int'($urandom_range(lat_max, lat_min));
            r.epoch = epoch;
            rq.push_back(r);
            issued++;
        end
        outstanding += int'(acc) - int'(vld);

        if (fr_cmd && !fr_prev) begin
            epoch++;
            issued  = 0;
            exp_ovf = 1'b0;
        end
        fr_prev = fr_cmd;

        mem_waitrequest   = wt;
        mem_readdatavalid = vld;
        mem_readdata      = rdat;
        fifo_wrfull       = full;
        frame_restart     = fr_cmd;
    endtask

    initial begin
        reset_n           = 1'b0;
        frame_restart     = 1'b0;
        mem_waitrequest   = 1'b0;
        mem_readdata      = '0;
        mem_readdatavalid = 1'b0;
        fifo_wrusedw      = '0;
        fifo_wrfull       = 1'b0;

        // Reset values
        #22;
        chk("rst_mem_read", 32'(mem_read), 32'(0));
        chk("rst_mem_address", 32'(mem_address), 32'(BASE));
        chk("rst_fifo_wrreq", 32'(fifo_wrreq), 32'(0));
        chk("rst_fifo_data", 32'(fifo_data), 32'(0));
        chk("rst_fifo_sclr", 32'(fifo_sclr), 32'(1));
        chk("rst_overflow", 32'(overflow), 32'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // Fetch begins within two cycles of reset release
        step();
        step();
        chk("fetch_within_2", 32'(mem_read), 32'(1));

        // Fixed 3-cycle latency, zero wait except 5-cycle stall on index 7
        for (int i = 0; i < 30; i++) step();
        chk("hold7_stall_len", 32'(hold_cnt), 32'(5));
        hold7 = 1'b0;

        // Random waits, latencies and return gaps; one pixel dropped on full FIFO
        wait_pct = 30;
        ret_pct  = 75;
        lat_min  = 1;
        lat_max  = 6;
        for (int i = 0; i < 20; i++) step();
        full_once = 1'b1;
        for (int i = 0; i < 8000 && !(issued == PIX && outstanding == 0); i++) step();
        for (int i = 0; i < 4; i++) step();
        chk("frame_complete", 32'(issued == PIX && outstanding == 0), 32'(1));
        chk("frame_writes", 32'(dut_writes), 32'(PIX - 1));
        chk("done_no_read", 32'(mem_read), 32'(0));
        chk("overflow_sticky", 32'(overflow), 32'(1));

        // New frame with returns withheld: request count caps at MAX_PENDING
        fr_cmd = 1'b1;
        step();
        fr_cmd = 1'b0;
        ret_en = 1'b0;
        wait_pct = 0;
        for (int i = 0; i < 30; i++) step();
        chk("pending_cap", 32'(issued), 32'(MAXP));
        chk("cap_no_read", 32'(mem_read), 32'(0));

        // Returns every cycle at the cap: acceptance and return coincide
        ret_en  = 1'b1;
        ret_pct = 100;
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 30; i++) step();
        chk("cap_steady_flow", 32'(issued > MAXP), 32'(1));

        // Restart, then let the next frame build up 10 outstanding reads
        fr_cmd = 1'b1;
        step();
        step();
        fr_cmd = 1'b0;
        ret_old_only = 1'b1;
        lat_min = 2;
        lat_max = 4;
        for (int i = 0; i < 60 && issued < 10; i++) step();
        chk("ten_issued", 32'(issued), 32'(10));

        // Restart while a request is stalled: abandoned, pending reads discarded
        ret_en     = 1'b0;
        force_wait = 1'b1;
        fr_cmd     = 1'b1;
        step();
        force_wait = 1'b0;
        for (int i = 0; i < 3; i++) step();
        fr_cmd = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("flush_hold", 32'(mem_read), 32'(0));
        end
        chk("flush_sclr", 32'(fifo_sclr), 32'(1));

        // Next frame with FIFO nearly full: only 12 requests fit
        fifo_wrusedw = 10'd500;
        ret_en = 1'b1;
        for (int i = 0; i < 40; i++) step();
        chk("usedw_500_issued", 32'(issued), 32'(12));
        chk("usedw_500_stop", 32'(mem_read), 32'(0));
        fifo_wrusedw = 10'd0;
        ret_old_only = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("usedw_drop_resume", 32'(issued > 12), 32'(1));

        // Asynchronous reset mid-burst
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_mem_read", 32'(mem_read), 32'(0));
        chk("async_mem_address", 32'(mem_address), 32'(BASE));
        chk("async_fifo_wrreq", 32'(fifo_wrreq), 32'(0));
        chk("async_fifo_sclr", 32'(fifo_sclr), 32'(1));
        chk("async_overflow", 32'(overflow), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
